dot_product_seq: RTL and testbench

DOT_PRODUCT_SEQ -- requirements
Module: dot_product_seq

---
 rtl/dot_product_pkg.sv | 24 ++
 rtl/dot_product_mul_17s_11ns_17_1_1.sv | 22 ++
 rtl/dot_product_seq.sv | 115 +++++++++++
 tb/tb_dot_product_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// ----------------------------------------------------------------------------
// dot_product_pkg : shared widths, defaults and FSM state type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dot_product_pkg;

  localparam int A_W       = 17;
  localparam int B_W       = 11;
  localparam int PROD_W    = 17;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_N_MAX = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dot_product_mul_17s_11ns_17_1_1.sv
// ----------------------------------------------------------------------------
// dot_product_mul_17s_11ns_17_1_1 : combinational signed x unsigned multiply
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dot_product_mul_17s_11ns_17_1_1 #(
  parameter int DIN0_W = 17,
  parameter int DIN1_W = 11,
  parameter int DOUT_W = 17
) (
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  output logic [DOUT_W-1:0] dout
);

  // din1 is unsigned: a zero MSB keeps it non-negative in the signed multiply
  assign dout = DOUT_W'($signed(din0) * $signed({1'b0, din1}));

endmodule

`default_nettype wire

// File: rtl/dot_product_seq.sv
// ----------------------------------------------------------------------------
// dot_product_seq : sequential dot product of two memory-resident vectors
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dot_product_seq
  import dot_product_pkg::*;
#(
  parameter int N_MAX  = DEF_N_MAX,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [ADDR_W:0]   len,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_done,
  output logic [ADDR_W-1:0] a_address0,
  output logic              a_ce0,
  input  logic [A_W-1:0]    a_q0,
  output logic [ADDR_W-1:0] b_address0,
  output logic              b_ce0,
  input  logic [B_W-1:0]    b_q0,
  output logic [ACC_W-1:0]  ap_return
);

  localparam int CNT_W = ADDR_W + 1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   n;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   n_clamped;
  logic               last_issue;
  logic               valid;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   ret;
  logic [PROD_W-1:0]  prod;

  dot_product_mul_17s_11ns_17_1_1 #(
    .DIN0_W (A_W),
    .DIN1_W (B_W),
    .DOUT_W (PROD_W)
  ) u_mul (
    .din0 (a_q0),
    .din1 (b_q0),
    .dout (prod)
  );

  assign n_clamped  = (len > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : len;
  assign last_issue = ((idx + CNT_W'(1)) == n);
  assign acc_nxt    = valid ? acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : acc;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = (n_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle    = (state == S_IDLE);
    ap_done    = (state == S_DONE);
    ap_ready   = (state == S_DONE);
    a_ce0      = (state == S_FETCH);
    b_ce0      = (state == S_FETCH);
    a_address0 = idx[ADDR_W-1:0];
    b_address0 = idx[ADDR_W-1:0];
  end

  // Read data lands one cycle after ce, so valid tracks ce delayed by one.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      n     <= '0;
      idx   <= '0;
      acc   <= '0;
      valid <= 1'b0;
      ret   <= '0;
    end else begin
      valid <= (state == S_FETCH);
      acc   <= acc_nxt;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            n   <= n_clamped;
            idx <= '0;
            acc <= '0;
            if (n_clamped == '0) ret <= '0;
          end
        end
        S_FETCH: idx <= idx + CNT_W'(1);
        S_DRAIN: ret <= acc_nxt;
        default: ;
      endcase
    end
  end

  assign ap_return = ret;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_seq.sv
// Randomised and directed bench for dot_product_seq against an arithmetic model.
`default_nettype none

module tb_dot_product_seq;

  localparam int N_MAX  = 64;
  localparam int ADDR_W = 6;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              ap_start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              ap_idle, ap_ready, ap_done;
  logic [ADDR_W-1:0] a_address0, b_address0;
  logic              a_ce0, b_ce0;
  logic [16:0]       a_q0 = '0;
  logic [10:0]       b_q0 = '0;
  logic [ACC_W-1:0]  ap_return;

  logic signed [16:0] a_mem [N_MAX];
  logic        [10:0] b_mem [N_MAX];
  logic [31:0]        prev_ret;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dot_product_seq #(.N_MAX(N_MAX), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .ap_clk     (clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .len        (len),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .a_address0 (a_address0),
    .a_ce0      (a_ce0),
    .a_q0       (a_q0),
    .b_address0 (b_address0),
    .b_ce0      (b_ce0),
    .b_q0       (b_q0),
    .ap_return  (ap_return)
  );

  // Memories with one-cycle read latency
  always @(posedge clk) begin
    if (a_ce0) a_q0 <= a_mem[a_address0];
    if (b_ce0) b_q0 <= b_mem[b_address0];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int ln);
    logic [31:0] s;
    int          n;
    s = '0;
    n = (ln > N_MAX) ? N_MAX : ln;
    for (int k = 0; k < n; k++) begin
      longint      p;
      logic [63:0] pv;
      logic [16:0] t;
      p  = longint'(a_mem[k]) * longint'(b_mem[k]);
      pv = p;
      t  = pv[16:0];
      s  = s + {{15{t[16]}}, t};
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int ln, input logic [31:0] exp_ret,
                     input bit hold, input bit poke);
    int n, exp_lat, cyc, ces;
    bit seen;
    n       = (ln > N_MAX) ? N_MAX : ln;
    exp_lat = (n == 0) ? 1 : n + 2;
    check_eq({tag, ":idle_at_start"}, 64'(ap_idle), 64'd1);
    ap_start = 1'b1;
    len      = 7'(ln);
    tick();
    cyc = 1; ces = 0; seen = 1'b0;
    ap_start = hold;
    len      = ~len;
    if (exp_lat > 1) check_eq({tag, ":ret_held"}, 64'(ap_return), 64'(prev_ret));
    while (cyc <= 200 && !seen) begin
      if (poke && n >= 1 && cyc == 2) begin
        ap_start = 1'b1;
        len      = 7'd5;
      end else if (poke && n >= 1 && cyc == 3) begin
        ap_start = hold;
      end
      if (a_ce0) begin
        check_eq({tag, ":a_addr"}, 64'(a_address0), 64'(ces));
        check_eq({tag, ":b_addr"}, 64'(b_address0), 64'(ces));
        ces++;
      end
      if (ap_done) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    check_eq({tag, ":done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, ":latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, ":ce_count"}, 64'(ces), 64'(n));
    check_eq({tag, ":ready"}, 64'(ap_ready), 64'd1);
    check_eq({tag, ":ret"}, 64'(ap_return), 64'(exp_ret));
    tick();
    check_eq({tag, ":done_one_cycle"}, 64'(ap_done), 64'd0);
    check_eq({tag, ":ret_after"}, 64'(ap_return), 64'(exp_ret));
    prev_ret = exp_ret;
  endtask

  initial begin
    int done_cnt;
    prev_ret = '0;
    for (int k = 0; k < N_MAX; k++) begin
      a_mem[k] = '0;
      b_mem[k] = '0;
    end

    tick();
    tick();
    check_eq("rst:idle", 64'(ap_idle), 64'd1);
    check_eq("rst:done", 64'(ap_done), 64'd0);
    check_eq("rst:ready", 64'(ap_ready), 64'd0);
    check_eq("rst:ce", 64'({a_ce0, b_ce0}), 64'd0);
    check_eq("rst:ret", 64'(ap_return), 64'd0);
    ap_rst = 1'b0;
    tick();

    a_mem[0] = 17'sd1;  a_mem[1] = -17'sd2; a_mem[2] = 17'sd3;
    b_mem[0] = 11'd4;   b_mem[1] = 11'd5;   b_mem[2] = 11'd6;
    run("len3", 3, 32'd12, 1'b0, 1'b0);

    run("len0", 0, 32'd0, 1'b0, 1'b0);

    a_mem[0] = -17'sd65536; b_mem[0] = 11'd2;
    run("trunc", 1, 32'd0, 1'b0, 1'b0);
    a_mem[0] = -17'sd1; b_mem[0] = 11'd2047;
    run("neg", 1, 32'(-2047), 1'b0, 1'b0);

    for (int k = 0; k < N_MAX; k++) begin
      a_mem[k] = 17'sd1;
      b_mem[k] = 11'(k);
    end
    run("clamp", 100, 32'd2016, 1'b0, 1'b0);

    for (int k = 0; k < N_MAX; k++) begin
      a_mem[k] = 17'(k + 1);
      b_mem[k] = 11'd3;
    end
    run("poke", 8, 32'd108, 1'b0, 1'b1);

    // Abort a run mid-fetch
    ap_start = 1'b1;
    len      = 7'd8;
    tick();
    ap_start = 1'b0;
    tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check_eq("abort:idle", 64'(ap_idle), 64'd1);
    check_eq("abort:ce", 64'({a_ce0, b_ce0}), 64'd0);
    check_eq("abort:ret", 64'(ap_return), 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (ap_done) done_cnt++;
      tick();
    end
    check_eq("abort:no_done", 64'(done_cnt), 64'd0);
    prev_ret = '0;
    run("after_abort", 8, 32'd108, 1'b0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      int ln;
      bit hold;
      for (int k = 0; k < N_MAX; k++) begin
        a_mem[k] = 17'($urandom);
        b_mem[k] = 11'($urandom);
      end
      ln   = (r % 5 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 80));
      hold = (r < 15) ? bit'($urandom_range(0, 1)) : 1'b0;
      run($sformatf("rand%0d", r), ln, model(ln), hold, bit'($urandom_range(0, 1)));
    end
    ap_start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
